// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg -- shared definitions for the puc_rs5_rtc machine timer.
//
// Contents:
//   MTIME_OFF / MTIMECMP_OFF : byte offsets of the two 64-bit registers
//   REG_SEL_BIT              : address bit choosing mtime vs mtimecmp
//   WORD_SEL_BIT             : address bit choosing low vs high 32-bit word
//   MTIME_RST / MTIMECMP_RST : register reset values
//   lane_rot()               : swaps the 32-bit halves when the high word is addressed
//   byte_merge()             : byte-enable merge of bus data into a register,
//                              with the same 32-bit lane rotation applied
// ---------------------------------------------------------------------------
package rtc_pkg;

   localparam logic [3:0]  MTIME_OFF    = 4'h0;
   localparam logic [3:0]  MTIMECMP_OFF = 4'h8;
   localparam int          REG_SEL_BIT  = 3;
   localparam int          WORD_SEL_BIT = 2;

   localparam logic [63:0] MTIME_RST    = 64'h0000_0000_0000_0000;
   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   // Addressing the high word puts it on bus lanes [31:0], so a 32-bit
   // master can reach either half through the low lanes.
   function automatic logic [63:0] lane_rot(input logic [63:0] v, input logic hi);
      return hi ? {v[31:0], v[63:32]} : v;
   endfunction

   function automatic logic [63:0] byte_merge(input logic [63:0] cur,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  we,
                                              input logic        hi);
      logic [63:0] d;
      logic [7:0]  m;
      logic [63:0] res;
      d   = lane_rot(wdata, hi);
      m   = hi ? {we[3:0], we[7:4]} : we;
      res = cur;
      for (int k = 0; k < 8; k++) begin
         if (m[k]) res[8*k +: 8] = d[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/puc_rs5_rtc_prescaler.sv
// ---------------------------------------------------------------------------
// rtc_prescaler -- tick generator for the machine timer.
//
// Counts 0..DIVIDER-1 and asserts tick while the count sits at DIVIDER-1,
// then wraps to 0. clr forces the count back to 0 (used when software
// writes mtime so the next increment is a full period away).
//
// Ports:
//   clk   in  1 : clock, rising edge
//   reset in  1 : asynchronous active-high reset
//   clr   in  1 : synchronous restart of the count
//   tick  out 1 : one-clock tick every DIVIDER clocks
// ---------------------------------------------------------------------------
module rtc_prescaler
   import rtc_pkg::*;
#(
   parameter int unsigned DIVIDER = 100
)
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int          CW   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/puc_rs5_rtc.sv
// ---------------------------------------------------------------------------
// puc_rs5_rtc -- memory-mapped RISC-V machine timer (mtime / mtimecmp).
//
// Free-running 64-bit mtime, 64-bit mtimecmp, level interrupt when
// mtime >= mtimecmp (unsigned). Only addr_i[3:0] is decoded:
//   addr_i[3] : 0 = mtime, 1 = mtimecmp
//   addr_i[2] : 0 = low word, 1 = high word (bus lanes rotated by 32 bits)
//
// Build option: define RTC_PRESCALER_EN to tick mtime every DIVIDER clocks
// via rtc_prescaler; otherwise mtime ticks every clock and DIVIDER is unused.
//
// Ports:
//   clk      in  1  : clock, rising edge
//   reset    in  1  : asynchronous active-high reset
//   en_i     in  1  : bus select
//   addr_i   in  4  : byte offset
//   we_i     in  8  : byte write enables (all zero = read)
//   data_i   in  64 : write data
//   data_o   out 64 : registered read data (held when not reading)
//   mti_o    out 1  : machine-timer interrupt
//   mtime_o  out 64 : current mtime
// ---------------------------------------------------------------------------
module puc_rs5_rtc
   import rtc_pkg::*;
#(
   parameter int unsigned DIVIDER = 100
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en_i,
   input  logic [3:0]  addr_i,
   input  logic [7:0]  we_i,
   input  logic [63:0] data_i,
   output logic [63:0] data_o,
   output logic        mti_o,
   output logic [63:0] mtime_o
);

   logic        sel_mtime;
   logic        sel_cmp;
   logic        word_hi;
   logic        wr_en;
   logic        rd_en;
   logic        wr_mtime;
   logic        wr_cmp;
   logic        tick;
   logic [63:0] mtime_q;
   logic [63:0] mtimecmp_q;
   logic [63:0] mtime_next;
   logic [63:0] mtimecmp_next;

   // addr_i[1:0] are don't-care byte offsets; DIVIDER only matters with the prescaler.
   wire unused_ok = &{1'b0, addr_i[1:0], DIVIDER[0]};

   assign sel_mtime = (addr_i[REG_SEL_BIT] == MTIME_OFF[REG_SEL_BIT]);
   assign sel_cmp   = (addr_i[REG_SEL_BIT] == MTIMECMP_OFF[REG_SEL_BIT]);
   assign word_hi   = addr_i[WORD_SEL_BIT];
   assign wr_en     = en_i && (we_i != 8'h00);
   assign rd_en     = en_i && (we_i == 8'h00);
   assign wr_mtime  = wr_en && sel_mtime;
   assign wr_cmp    = wr_en && sel_cmp;

`ifdef RTC_PRESCALER_EN
   rtc_prescaler #(
      .DIVIDER (DIVIDER)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (wr_mtime),
      .tick  (tick)
   );
`else
   assign tick = 1'b1;
`endif

   // A software write to mtime wins over that cycle's tick.
   always_comb begin
      mtime_next = mtime_q;
      if (wr_mtime) begin
         mtime_next = byte_merge(mtime_q, data_i, we_i, word_hi);
      end else if (tick) begin
         mtime_next = mtime_q + 64'd1;
      end
      mtimecmp_next = wr_cmp ? byte_merge(mtimecmp_q, data_i, we_i, word_hi) : mtimecmp_q;
   end

   // Interrupt is computed from the next-state values so it moves on the
   // same edge as the registers it depends on.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mtime_q    <= MTIME_RST;
         mtimecmp_q <= MTIMECMP_RST;
         mti_o      <= 1'b0;
         data_o     <= 64'h0;
      end else begin
         mtime_q    <= mtime_next;
         mtimecmp_q <= mtimecmp_next;
         mti_o      <= (mtime_next >= mtimecmp_next);
         if (rd_en) begin
            data_o <= lane_rot(sel_cmp ? mtimecmp_q : mtime_q, word_hi);
         end
      end
   end

   assign mtime_o = mtime_q;

endmodule

// File: tb/tb_puc_rs5_rtc.sv
module tb_puc_rs5_rtc;

`ifdef RTC_PRESCALER_EN
   localparam bit PRE = 1'b1;
`else
   localparam bit PRE = 1'b0;
`endif
   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en_i = 1'b0;
   logic [3:0]  addr_i = 4'h0;
   logic [7:0]  we_i = 8'h00;
   logic [63:0] data_i = 64'h0;
   logic [63:0] data_o;
   logic        mti_o;
   logic [63:0] mtime_o;

   int errs = 0;
   int checks = 0;

   // reference state
   logic [63:0] m_time;
   logic [63:0] m_cmp;
   logic [63:0] m_data;
   logic        m_mti;
   int          m_pc;

   puc_rs5_rtc #(.DIVIDER(DIV)) dut (
      .clk     (clk),
      .reset   (reset),
      .en_i    (en_i),
      .addr_i  (addr_i),
      .we_i    (we_i),
      .data_i  (data_i),
      .data_o  (data_o),
      .mti_o   (mti_o),
      .mtime_o (mtime_o)
   );

   always #5 clk = ~clk;

   // Bus byte k lands in register byte k, or byte (k+4) mod 8 for the high word.
   function automatic logic [63:0] apply_write(input logic [63:0] cur, input logic [63:0] wd,
                                               input logic [7:0] we, input logic hi);
      logic [63:0] r;
      int t;
      r = cur;
      for (int k = 0; k < 8; k++) begin
         t = hi ? ((k + 4) % 8) : k;
         if (we[k]) r[8*t +: 8] = wd[8*k +: 8];
      end
      return r;
   endfunction

   // Addressed word on data[31:0], the other word on data[63:32].
   function automatic logic [63:0] read_view(input logic [63:0] r, input logic hi);
      logic [31:0] addressed;
      logic [31:0] other;
      addressed = hi ? r[63:32] : r[31:0];
      other     = hi ? r[31:0]  : r[63:32];
      return {other, addressed};
   endfunction

   task automatic model_reset();
      m_time = 64'h0;
      m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
      m_data = 64'h0;
      m_mti  = 1'b0;
      m_pc   = 0;
   endtask

   // Drive one bus cycle (called away from the edges), advance the model
   // across the rising edge, return 1 time unit after it.
   task automatic cycle(input bit en, input logic [3:0] addr, input logic [7:0] we,
                        input logic [63:0] d);
      bit tick;
      en_i = en; addr_i = addr; we_i = we; data_i = d;
      @(posedge clk);
      tick = PRE ? (m_pc == DIV - 1) : 1'b1;
      if (en && we == 8'h00) m_data = read_view(addr[3] ? m_cmp : m_time, addr[2]);
      if (en && we != 8'h00 && !addr[3]) begin
         m_time = apply_write(m_time, d, we, addr[2]);
         m_pc   = 0;
      end else begin
         if (tick) m_time = m_time + 64'd1;
         m_pc = tick ? 0 : m_pc + 1;
      end
      if (en && we != 8'h00 && addr[3]) m_cmp = apply_write(m_cmp, d, we, addr[2]);
      m_mti = (m_time >= m_cmp);
      #1;
   endtask

   task automatic test_reset();
      logic [63:0] exp_t;
      #12;
      checks++; if (mtime_o !== 64'h0) begin errs++; $display("FAIL reset_mtime got=%h exp=0", mtime_o); end
      checks++; if (mti_o !== 1'b0) begin errs++; $display("FAIL reset_mti got=%b exp=0", mti_o); end
      checks++; if (data_o !== 64'h0) begin errs++; $display("FAIL reset_data got=%h exp=0", data_o); end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (10) cycle(0, 4'h0, 8'h00, 64'h0);
      exp_t = PRE ? 64'd2 : 64'd10;
      checks++; if (mtime_o !== exp_t) begin errs++; $display("FAIL count10 got=%0d exp=%0d", mtime_o, exp_t); end
      checks++; if (mti_o !== 1'b0) begin errs++; $display("FAIL count10_mti got=%b exp=0", mti_o); end
   endtask

   task automatic test_low_compare();
      bit rose;
      cycle(1, 4'h8, 8'h0F, 64'h20);
      cycle(1, 4'hC, 8'h0F, 64'h0);
      checks++; if (mti_o !== 1'b0) begin errs++; $display("FAIL cmp_armed got=%b exp=0", mti_o); end
      rose = 1'b0;
      for (int i = 0; i < 400 && !rose; i++) begin
         cycle(0, 4'h0, 8'h00, 64'h0);
         checks++;
         if (mti_o !== m_mti || mtime_o !== m_time) begin
            errs++; $display("FAIL cmp_track mti=%b/%b mtime=%h/%h", mti_o, m_mti, mtime_o, m_time);
         end
         rose = mti_o;
      end
      checks++; if (!rose) begin errs++; $display("FAIL cmp_rise_timeout got=0 exp=1"); end
      checks++; if (mtime_o !== 64'h20) begin errs++; $display("FAIL cmp_rise_at got=%h exp=20", mtime_o); end
      cycle(1, 4'hC, 8'h0F, 64'h1);
      checks++; if (mti_o !== 1'b0) begin errs++; $display("FAIL cmp_clear got=%b exp=0", mti_o); end
   endtask

   task automatic test_high_read();
      cycle(1, 4'h4, 8'h0F, 64'h5);
      cycle(1, 4'h0, 8'h0F, 64'hFFFF_FFFE);
      cycle(1, 4'h4, 8'h00, 64'h0);
      checks++; if (data_o[31:0] !== 32'h5) begin errs++; $display("FAIL hi_read got=%h exp=5", data_o[31:0]); end
      checks++; if (data_o !== m_data) begin errs++; $display("FAIL hi_read_full got=%h exp=%h", data_o, m_data); end
      for (int i = 0; i < 6; i++) begin
         cycle(1, 4'h0, 8'h00, 64'h0);
         checks++;
         if (data_o !== m_data || mti_o !== m_mti) begin
            errs++; $display("FAIL lo_read_wrap got=%h exp=%h mti=%b/%b", data_o, m_data, mti_o, m_mti);
         end
      end
      cycle(1, 4'h4, 8'h00, 64'h0);
      checks++;
      if (data_o !== m_data || (data_o[31:0] != 32'h5 && data_o[31:0] != 32'h6)) begin
         errs++; $display("FAIL hi_read_carry got=%h exp=%h", data_o, m_data);
      end
   endtask

   task automatic test_byte_write();
      cycle(1, 4'h8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      cycle(1, 4'h8, 8'h01, 64'hAB);
      cycle(1, 4'h8, 8'h00, 64'h0);
      checks++; if (data_o !== 64'hFFFF_FFFF_FFFF_FFAB) begin errs++; $display("FAIL byte_lo got=%h exp=ffffffffffffffab", data_o); end
      cycle(1, 4'hC, 8'h00, 64'h0);
      checks++; if (data_o !== 64'hFFFF_FFAB_FFFF_FFFF) begin errs++; $display("FAIL byte_hi_view got=%h exp=ffffffabffffffff", data_o); end
      // upper bus lanes of a high-word access reach register bytes 3..0
      cycle(1, 4'hC, 8'h10, 64'h0000_0012_0000_0000);
      cycle(1, 4'h8, 8'h00, 64'h0);
      checks++; if (data_o !== 64'hFFFF_FFFF_FFFF_FF12) begin errs++; $display("FAIL byte_rot got=%h exp=ffffffffffffff12", data_o); end
   endtask

   task automatic test_wrap();
      bit done;
      cycle(1, 4'h0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      checks++; if (mtime_o !== 64'hFFFF_FFFF_FFFF_FFFF || mti_o !== 1'b1) begin
         errs++; $display("FAIL wrap_set mtime=%h mti=%b exp=ffffffffffffffff/1", mtime_o, mti_o);
      end
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
         cycle(0, 4'h0, 8'h00, 64'h0);
         checks++;
         if (mtime_o !== m_time || mti_o !== m_mti) begin
            errs++; $display("FAIL wrap_track mtime=%h/%h mti=%b/%b", mtime_o, m_time, mti_o, m_mti);
         end
         done = (m_time == 64'h0);
      end
      checks++; if (mtime_o !== 64'h0 || mti_o !== 1'b0) begin
         errs++; $display("FAIL wrap_zero mtime=%h mti=%b exp=0/0", mtime_o, mti_o);
      end
   endtask

   task automatic test_tick_rate();
      int n;
      int exp_n;
      exp_n = PRE ? DIV : 1;
      cycle(1, 4'h0, 8'hFF, 64'd100);
      n = 0;
      for (int i = 0; i < 20 && mtime_o == 64'd100; i++) begin
         cycle(0, 4'h0, 8'h00, 64'h0);
         n++;
      end
      checks++; if (n != exp_n) begin errs++; $display("FAIL tick_period got=%0d exp=%0d", n, exp_n); end
      checks++; if (mtime_o !== 64'd101) begin errs++; $display("FAIL tick_value got=%0d exp=101", mtime_o); end
   endtask

   task automatic test_back_to_back();
      bit          en;
      logic [3:0]  addr;
      logic [7:0]  we;
      logic [63:0] d;
      for (int i = 0; i < 300; i++) begin
         en   = ($urandom_range(3) != 0);
         addr = 4'($urandom_range(15));
         we   = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(255));
         d    = {$urandom, $urandom};
         // keep mtime writes near mtimecmp so the interrupt toggles
         if ($urandom_range(3) == 0) d = m_cmp - 64'($urandom_range(3));
         cycle(en, addr, we, d);
         checks++;
         if (data_o !== m_data || mtime_o !== m_time || mti_o !== m_mti) begin
            errs++;
            $display("FAIL random[%0d] data=%h/%h mtime=%h/%h mti=%b/%b", i, data_o, m_data,
                     mtime_o, m_time, mti_o, m_mti);
         end
      end
   endtask

   task automatic test_reset_mid();
      cycle(1, 4'h8, 8'h0F, 64'h3);
      cycle(1, 4'h0, 8'h00, 64'h0);
      #2;
      reset = 1'b1;
      #1;
      checks++; if (mtime_o !== 64'h0 || mti_o !== 1'b0 || data_o !== 64'h0) begin
         errs++; $display("FAIL reset_mid mtime=%h mti=%b data=%h exp=0", mtime_o, mti_o, data_o);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      cycle(1, 4'hC, 8'h00, 64'h0);
      checks++; if (data_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errs++; $display("FAIL reset_mid_cmp got=%h exp=ffffffffffffffff", data_o);
      end
      for (int i = 0; i < 2 * DIV; i++) begin
         cycle(0, 4'h0, 8'h00, 64'h0);
         checks++; if (mtime_o !== m_time) begin errs++; $display("FAIL reset_mid_count got=%h exp=%h", mtime_o, m_time); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_low_compare();
      test_high_read();
      test_byte_write();
      test_wrap();
      test_tick_rate();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
